// File: rtl/player_motion_if.sv
`default_nettype none
// ============================================================================
// player_motion_if : frame/control inputs and position/status outputs of the
//                    player motion controller.                       rev 1.0
// ============================================================================
interface player_motion_if;
  logic             startOfFrame;
  logic             left;
  logic             right;
  logic             up;
  logic             down;
  logic             collision;
  logic             invincible;
  logic [1:0][10:0] coordinate;
  logic [3:0]       lives;
  logic [1:0]       state;
  logic             visible;
  logic             gameOver;

  modport master (
    output startOfFrame, left, right, up, down, collision, invincible,
    input  coordinate, lives, state, visible, gameOver
  );

  modport slave (
    input  startOfFrame, left, right, up, down, collision, invincible,
    output coordinate, lives, state, visible, gameOver
  );
endinterface
`default_nettype wire

// File: rtl/player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// player_motion_ctrl : fixed-point X/Y player motion with drag and clamping,
//                      plus a lives/hit/shield state machine.         rev 1.0
// ============================================================================
module player_motion_ctrl #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int IMAGE_WIDTH   = 32,
  parameter int IMAGE_HEIGHT  = 32,
  parameter int INITIAL_X     = 303,
  parameter int INITIAL_Y     = 415,
  parameter int FRAC_BITS     = 6,
  parameter int ACCEL         = 25,
  parameter int MAX_SPEED     = 150,
  parameter int ENABLE_Y      = 0,
  parameter int START_LIVES   = 3,
  parameter int HIT_FRAMES    = 60,
  parameter int SHIELD_FRAMES = 150
) (
  input  logic             clk,
  input  logic             reset,
  player_motion_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_HIT    = 2'd1,
    ST_SHIELD = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [31:0] pos;
    logic signed [31:0] vel;
  } axis_t;

  localparam logic signed [31:0] c_accel     = 32'(ACCEL);
  localparam logic signed [31:0] c_max_speed = 32'(MAX_SPEED);
  localparam logic signed [31:0] c_max_x     = 32'((SCREEN_WIDTH - IMAGE_WIDTH) << FRAC_BITS);
  localparam logic signed [31:0] c_max_y     = 32'((SCREEN_HEIGHT - IMAGE_HEIGHT) << FRAC_BITS);
  localparam logic signed [31:0] c_init_x    = 32'(INITIAL_X << FRAC_BITS);
  localparam logic signed [31:0] c_init_y    = 32'(INITIAL_Y << FRAC_BITS);
  localparam logic [7:0]         c_hit       = 8'(HIT_FRAMES);
  localparam logic [7:0]         c_shield    = 8'(SHIELD_FRAMES);
  localparam logic [3:0]         c_lives     = 4'(START_LIVES);

  // One frame of motion on one axis: accelerate or drag, then clamp to [0, lim].
  function automatic axis_t f_axis(input axis_t cur, input logic inc, input logic dec,
                                   input logic signed [31:0] lim);
    axis_t              nxt;
    logic signed [31:0] v;
    logic signed [31:0] s;
    if (inc && !dec)
      v = (cur.vel >= c_max_speed - c_accel) ? c_max_speed : cur.vel + c_accel;
    else if (dec && !inc)
      v = (cur.vel <= c_accel - c_max_speed) ? -c_max_speed : cur.vel - c_accel;
    else if (cur.vel > c_accel)
      v = cur.vel - c_accel;
    else if (cur.vel < -c_accel)
      v = cur.vel + c_accel;
    else
      v = '0;
    s = cur.pos + v;
    if (s < 0) begin
      nxt.pos = '0;
      nxt.vel = '0;
    end else if (s > lim) begin
      nxt.pos = lim;
      nxt.vel = '0;
    end else begin
      nxt.pos = s;
      nxt.vel = v;
    end
    return nxt;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] lives_q, lives_d;
  logic       visible_q;
  logic       game_over_q;
  axis_t      axis_x_q, axis_x_d;
  axis_t      axis_y_q, axis_y_d;
  logic       move_w;

  // Motion is gated by the state held before this cycle's FSM update.
  assign move_w   = bus.startOfFrame && (state_q != ST_DEAD);
  assign axis_x_d = move_w ? f_axis(axis_x_q, bus.right, bus.left, c_max_x) : axis_x_q;

  generate
    if (ENABLE_Y != 0) begin : g_y_motion
      assign axis_y_d = move_w ? f_axis(axis_y_q, bus.down, bus.up, c_max_y) : axis_y_q;
    end else begin : g_y_fixed
      assign axis_y_d = axis_y_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      axis_x_q <= '{pos: c_init_x, vel: '0};
      axis_y_q <= '{pos: c_init_y, vel: '0};
    end else begin
      axis_x_q <= axis_x_d;
      axis_y_q <= axis_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lives_d = lives_q;
    case (state_q)
      ST_ALIVE: begin
        if (bus.invincible) begin
          state_d = ST_SHIELD;
          timer_d = c_shield;
        end else if (bus.collision) begin
          if (lives_q <= 4'd1) begin
            lives_d = '0;
            state_d = ST_DEAD;
            timer_d = '0;
          end else begin
            lives_d = lives_q - 4'd1;
            state_d = ST_HIT;
            timer_d = c_hit;
          end
        end
      end
      ST_HIT, ST_SHIELD: begin
        // A fresh load takes priority over the frame decrement.
        if (bus.invincible) begin
          state_d = ST_SHIELD;
          timer_d = c_shield;
        end else if (bus.startOfFrame) begin
          if (timer_q <= 8'd1) begin
            state_d = ST_ALIVE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ALIVE;
      timer_q     <= '0;
      lives_q     <= c_lives;
      visible_q   <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      lives_q     <= lives_d;
      visible_q   <= (state_d == ST_HIT) ? timer_d[2] : 1'b1;
      game_over_q <= (state_d == ST_DEAD);
    end
  end

  assign bus.coordinate[0] = 11'(axis_x_q.pos >>> FRAC_BITS);
  assign bus.coordinate[1] = 11'(axis_y_q.pos >>> FRAC_BITS);
  assign bus.lives         = lives_q;
  assign bus.state         = state_q;
  assign bus.visible       = visible_q;
  assign bus.gameOver      = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// ============================================================================
// tb_player_motion_ctrl : directed vector table plus hand-written sequences
//                         for the player motion controller.          rev 1.0
// ============================================================================
module tb_player_motion_ctrl;
  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] H = 2'd1;
  localparam logic [1:0] S = 2'd2;
  localparam logic [1:0] D = 2'd3;

  typedef struct {
    logic rst, sof, l, r, u, d, c, i;
    int         ex, ey;
    logic [3:0] el;
    logic [1:0] es;
    logic       ev, eg;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  player_motion_if bus ();

  player_motion_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, sof, l, r, u, d, c, i);
    reset            = rst;
    bus.startOfFrame = sof;
    bus.left         = l;
    bus.right        = r;
    bus.up           = u;
    bus.down         = d;
    bus.collision    = c;
    bus.invincible   = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int idx, input int ex, input int ey,
                       input logic [3:0] el, input logic [1:0] es, input logic ev, input logic eg);
    int ax, ay;
    ax = int'($signed(bus.coordinate[0]));
    ay = int'($signed(bus.coordinate[1]));
    n_tests++;
    if (ax !== ex || ay !== ey || bus.lives !== el || bus.state !== es ||
        bus.visible !== ev || bus.gameOver !== eg) begin
      n_fail++;
      $display("FAIL %s[%0d]: got x=%0d y=%0d lives=%0d state=%0d vis=%0b go=%0b, expected x=%0d y=%0d lives=%0d state=%0d vis=%0b go=%0b",
               tag, idx, ax, ay, bus.lives, bus.state, bus.visible, bus.gameOver,
               ex, ey, el, es, ev, eg);
    end
  endtask

  task automatic add(input logic rst, sof, l, r, u, d, c, i, input int ex, input int ey,
                     input logic [3:0] el, input logic [1:0] es, input logic ev, input logic eg);
    vec_t v;
    v = '{rst, sof, l, r, u, d, c, i, ex, ey, el, es, ev, eg};
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].sof, tbl[k].l, tbl[k].r, tbl[k].u, tbl[k].d, tbl[k].c, tbl[k].i);
      check(tag, k, tbl[k].ex, tbl[k].ey, tbl[k].el, tbl[k].es, tbl[k].ev, tbl[k].eg);
    end
    tbl.delete();
  endtask

  task automatic frames(input int n);
    repeat (n) drive(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int xs[10];
    xs = '{303, 304, 305, 306, 308, 311, 313, 315, 318, 320};
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Acceleration, saturation, drag, reversal; Y stays put with ENABLE_Y=0.
    add(1,0,0,0,0,0,0,0, 303,415, 3,A,1,0);
    for (int k = 0; k < 10; k++) add(0,1,0,1,0,0,0,0, xs[k],415, 3,A,1,0);
    add(0,1,1,1,0,0,0,0, 322,415, 3,A,1,0);
    add(0,1,0,0,0,0,0,0, 324,415, 3,A,1,0);
    add(0,1,0,0,0,1,0,0, 325,415, 3,A,1,0);
    add(0,1,0,0,1,0,0,0, 326,415, 3,A,1,0);
    add(0,1,0,0,0,0,0,0, 326,415, 3,A,1,0);
    add(0,1,0,0,0,0,0,0, 326,415, 3,A,1,0);
    add(0,0,0,1,0,0,0,0, 326,415, 3,A,1,0);
    add(0,1,1,0,0,0,0,0, 326,415, 3,A,1,0);
    add(0,1,1,0,0,0,0,0, 325,415, 3,A,1,0);
    add(0,1,0,1,0,0,0,0, 324,415, 3,A,1,0);
    add(0,1,0,1,0,0,0,0, 324,415, 3,A,1,0);
    add(0,1,0,1,0,0,0,0, 325,415, 3,A,1,0);
    run_table("motion");

    // Right edge: clamp at 608 and velocity cleared.
    for (int k = 0; k < 400; k++) begin
      if ($signed(bus.coordinate[0]) == 11'sd608) break;
      drive(0, 1, 0, 1, 0, 0, 0, 0);
    end
    check("edge_right", 0, 608, 415, 3, A, 1, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    check("edge_release", 0, 608, 415, 3, A, 1, 0);
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    check("edge_right_vel0", 0, 607, 415, 3, A, 1, 0);

    // Left edge: clamp at 0 and velocity cleared.
    for (int k = 0; k < 400; k++) begin
      if ($signed(bus.coordinate[0]) == 11'sd0) break;
      drive(0, 1, 1, 0, 0, 0, 0, 0);
    end
    check("edge_left", 0, 0, 415, 3, A, 1, 0);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    check("edge_left_vel0", 0, 1, 415, 3, A, 1, 0);

    // Hit with coincident frame pulse, then blink pattern of the timer.
    add(1,0,0,0,0,0,0,0, 303,415, 3,A,1,0);
    add(0,1,0,0,0,0,1,0, 303,415, 2,H,1,0);
    add(0,0,0,0,0,0,1,0, 303,415, 2,H,1,0);
    add(0,1,0,0,0,0,0,0, 303,415, 2,H,0,0);
    add(0,1,0,0,0,0,0,0, 303,415, 2,H,0,0);
    add(0,1,0,0,0,0,0,0, 303,415, 2,H,0,0);
    add(0,1,0,0,0,0,0,0, 303,415, 2,H,0,0);
    add(0,1,0,0,0,0,0,0, 303,415, 2,H,1,0);
    run_table("hit");
    frames(54);
    check("hit_last", 0, 303, 415, 2, H, 0, 0);
    frames(1);
    check("hit_end", 0, 303, 415, 2, A, 1, 0);

    // Collision and invincible together: shield wins; reload on repeat request.
    add(0,0,0,0,0,0,1,1, 303,415, 2,S,1,0);
    run_table("shield");
    frames(100);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("shield_coll", 0, 303, 415, 2, S, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    frames(149);
    check("shield_reload", 0, 303, 415, 2, S, 1, 0);
    frames(1);
    check("shield_end", 0, 303, 415, 2, A, 1, 0);

    // HIT -> SHIELD, then last life, DEAD freeze, reset out of DEAD and mid-HIT.
    add(0,0,0,0,0,0,1,0, 303,415, 1,H,1,0);
    add(0,0,0,0,0,0,0,1, 303,415, 1,S,1,0);
    run_table("hit_shield");
    frames(149);
    check("hs_last", 0, 303, 415, 1, S, 1, 0);
    frames(1);
    check("hs_end", 0, 303, 415, 1, A, 1, 0);
    add(0,0,0,0,0,0,1,0, 303,415, 0,D,1,1);
    add(0,1,0,1,0,0,0,0, 303,415, 0,D,1,1);
    add(0,0,0,0,0,0,1,0, 303,415, 0,D,1,1);
    add(0,0,0,0,0,0,0,1, 303,415, 0,D,1,1);
    add(1,0,0,0,0,0,1,0, 303,415, 3,A,1,0);
    add(0,1,0,1,0,0,0,0, 303,415, 3,A,1,0);
    add(0,1,0,1,0,0,0,0, 304,415, 3,A,1,0);
    add(0,0,0,0,0,0,1,0, 304,415, 2,H,1,0);
    add(1,1,0,1,0,0,1,0, 303,415, 3,A,1,0);
    add(0,1,1,0,0,0,0,0, 302,415, 3,A,1,0);
    run_table("dead_reset");

    // Three collisions with the grace period elapsing in between.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("x3_hit1", 0, 302, 415, 2, H, 1, 0);
    frames(60);
    check("x3_alive1", 0, 302, 415, 2, A, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("x3_hit2", 0, 302, 415, 1, H, 1, 0);
    frames(60);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    check("x3_dead", 0, 302, 415, 0, D, 1, 1);
    drive(0, 1, 0, 1, 0, 0, 0, 0);
    check("x3_frozen", 0, 302, 415, 0, D, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
